// File: rtl/lemmings_splat_fsm.sv
// lemmings_splat_fsm: per-lemming walk/fall/dig controller with a fall-height
// limit. A fall lasting more than FALL_LIMIT cycles ends in a terminal SPLAT
// state that only reset can leave.
//
// Optional feature macro: LEMMINGS_BUMP_CNT_EN
//   When defined, adds the bump_count output, a BUMP_W-bit wrapping count of
//   bump-induced turns. When undefined the port and its register are absent.
//
// All outputs are registered and decoded from the next state, so each output
// is a pure function of the current state with no path from the inputs.

module lemmings_splat_fsm #(
    parameter int FALL_LIMIT = 20,
    parameter int BUMP_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bump_left,
    input  logic              bump_right,
    input  logic              ground,
    input  logic              dig,
    output logic              walk_left,
    output logic              walk_right,
    output logic              aaah,
    output logic              digging,
    output logic              splat
`ifdef LEMMINGS_BUMP_CNT_EN
    ,
    output logic [BUMP_W-1:0] bump_count
`endif
);

    // Wide enough to hold the saturated value FALL_LIMIT itself.
    localparam int FCNT_W = $clog2(FALL_LIMIT + 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FALL_LIMIT);

    // Reject parameter values the counter logic cannot represent.
    if (FALL_LIMIT < 1 || BUMP_W < 1) begin : g_param_check
        $error("lemmings_splat_fsm: FALL_LIMIT and BUMP_W must both be >= 1");
    end

    typedef enum logic [2:0] {
        S_WL    = 3'd0,
        S_WR    = 3'd1,
        S_FL    = 3'd2,
        S_FR    = 3'd3,
        S_DL    = 3'd4,
        S_DR    = 3'd5,
        S_SPLAT = 3'd6
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [FCNT_W-1:0]   fall_cnt_q;
    logic [FCNT_W-1:0]   fall_cnt_d;
    logic                bump_turn;

    // Saturating increment of the fall length; never wraps past FALL_LIMIT.
    function automatic logic [FCNT_W-1:0] fall_inc(input logic [FCNT_W-1:0] cnt);
        if (cnt >= FCNT_MAX) begin
            return FCNT_MAX;
        end
        return cnt + FCNT_W'(1);
    endfunction

    // Next-state logic; fall_cnt defaults to zero so it stays cleared outside falls.
    always_comb begin
        state_d    = state_q;
        fall_cnt_d = '0;
        bump_turn  = 1'b0;
        case (state_q)
            S_WL: begin
                if (!ground) begin
                    state_d = S_FL;
                end else if (dig) begin
                    state_d = S_DL;
                end else if (bump_left) begin
                    state_d   = S_WR;
                    bump_turn = 1'b1;
                end
            end
            S_WR: begin
                if (!ground) begin
                    state_d = S_FR;
                end else if (dig) begin
                    state_d = S_DR;
                end else if (bump_right) begin
                    state_d   = S_WL;
                    bump_turn = 1'b1;
                end
            end
            S_FL: begin
                if (!ground) begin
                    fall_cnt_d = fall_inc(fall_cnt_q);
                end else if (fall_cnt_q >= FCNT_MAX) begin
                    state_d = S_SPLAT;
                end else begin
                    state_d = S_WL;
                end
            end
            S_FR: begin
                if (!ground) begin
                    fall_cnt_d = fall_inc(fall_cnt_q);
                end else if (fall_cnt_q >= FCNT_MAX) begin
                    state_d = S_SPLAT;
                end else begin
                    state_d = S_WR;
                end
            end
            S_DL: begin
                if (!ground) begin
                    state_d = S_FL;
                end
            end
            S_DR: begin
                if (!ground) begin
                    state_d = S_FR;
                end
            end
            S_SPLAT: begin
                state_d = S_SPLAT;
            end
            default: begin
                state_d = S_WL;
            end
        endcase
    end

    // State, fall counter and registered one-hot status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_WL;
            fall_cnt_q <= '0;
            walk_left  <= 1'b1;
            walk_right <= 1'b0;
            aaah       <= 1'b0;
            digging    <= 1'b0;
            splat      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fall_cnt_q <= fall_cnt_d;
            walk_left  <= (state_d == S_WL);
            walk_right <= (state_d == S_WR);
            aaah       <= (state_d == S_FL) || (state_d == S_FR);
            digging    <= (state_d == S_DL) || (state_d == S_DR);
            splat      <= (state_d == S_SPLAT);
        end
    end

`ifdef LEMMINGS_BUMP_CNT_EN
    // Count bump-caused turns; wraps naturally, frozen in SPLAT since no turn occurs there.
    always_ff @(posedge clk) begin
        if (reset) begin
            bump_count <= '0;
        end else if (bump_turn) begin
            bump_count <= bump_count + BUMP_W'(1);
        end
    end
`else
    // bump_turn only feeds the optional counter.
    logic unused_bump_turn;
    assign unused_bump_turn = bump_turn;
`endif

endmodule

// File: tb/tb_lemmings_splat_fsm.sv
// Self-checking bench for lemmings_splat_fsm: a mode/direction/fall-length
// model is compared against the DUT outputs every cycle, plus literal checks
// on directed scenarios, followed by randomized stimulus.

module tb_lemmings_splat_fsm;

    localparam int FALL_LIMIT = 20;
    localparam int BUMP_W     = 2;

    logic clk;
    logic reset;
    logic bump_left;
    logic bump_right;
    logic ground;
    logic dig;
    logic walk_left;
    logic walk_right;
    logic aaah;
    logic digging;
    logic splat;
`ifdef LEMMINGS_BUMP_CNT_EN
    logic [BUMP_W-1:0] bump_count;
`endif

    lemmings_splat_fsm #(
        .FALL_LIMIT(FALL_LIMIT),
        .BUMP_W    (BUMP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bump_left (bump_left),
        .bump_right(bump_right),
        .ground    (ground),
        .dig       (dig),
        .walk_left (walk_left),
        .walk_right(walk_right),
        .aaah      (aaah),
        .digging   (digging),
        .splat     (splat)
`ifdef LEMMINGS_BUMP_CNT_EN
        ,
        .bump_count(bump_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // Behavioural model: mode 0 walk, 1 fall, 2 dig, 3 splat; dir 0 left, 1 right.
    int m_mode  = 0;
    int m_dir   = 0;
    int m_g     = 0;
    int m_bumps = 0;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit bl, input bit br, input bit g, input bit d);
        if (r) begin
            m_mode = 0; m_dir = 0; m_g = 0; m_bumps = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (!g) begin
                        m_mode = 1; m_g = 1;
                    end else if (d) begin
                        m_mode = 2;
                    end else if ((m_dir == 0) ? bl : br) begin
                        m_dir = 1 - m_dir; m_bumps++;
                    end
                end
                1: begin
                    if (!g) m_g++;
                    else if (m_g > FALL_LIMIT) m_mode = 3;
                    else m_mode = 0;
                end
                2: begin
                    if (!g) begin
                        m_mode = 1; m_g = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, settle 1 time unit.
    task automatic step(input bit r, input bit bl, input bit br, input bit g, input bit d);
        reset = r; bump_left = bl; bump_right = br; ground = g; dig = d;
        @(posedge clk);
        model_update(r, bl, br, g, d);
        #1;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("walk_left",  int'(walk_left),  int'(m_mode == 0 && m_dir == 0));
            check("walk_right", int'(walk_right), int'(m_mode == 0 && m_dir == 1));
            check("aaah",       int'(aaah),       int'(m_mode == 1));
            check("digging",    int'(digging),    int'(m_mode == 2));
            check("splat",      int'(splat),      int'(m_mode == 3));
`ifdef LEMMINGS_BUMP_CNT_EN
            check("bump_count", int'(bump_count), m_bumps % (1 << BUMP_W));
`endif
        end
    end

    initial begin
        int cnt;
        int run;
        reset = 1'b1; bump_left = 1'b0; bump_right = 1'b0; ground = 1'b1; dig = 1'b0;

        // Reset, then idle walking left; a left bump turns right.
        step(1, 0, 0, 1, 0);
        chk_en = 1'b1;
        step(1, 0, 0, 1, 0);
        check("rst_walk_left", int'(walk_left), 1);
        check("rst_others", int'({walk_right, aaah, digging, splat}), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        check("idle_walk_left", int'(walk_left), 1);
        step(0, 1, 0, 1, 0);
        check("bump_turn_right", int'(walk_right), 1);

        // Fall beats dig; direction is kept after a short fall.
        step(0, 0, 0, 0, 1);
        check("fall_beats_dig", int'(aaah), 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        check("land_walk_right", int'(walk_right), 1);

        // Exactly FALL_LIMIT low edges survive.
        step(1, 0, 0, 1, 0);
        cnt = 0;
        for (int i = 0; i < FALL_LIMIT; i++) begin
            step(0, 0, 0, 0, 0);
            if (aaah) cnt++;
        end
        step(0, 0, 0, 1, 0);
        check("aaah_cycles_20", cnt, 20);
        check("survive_20", int'(walk_left), 1);

        // FALL_LIMIT+1 low edges splat; splat ignores everything but reset.
        for (int i = 0; i < FALL_LIMIT + 1; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("splat_21", int'(splat), 1);
        check("splat_others", int'({walk_left, walk_right, aaah, digging}), 0);
        for (int i = 0; i < 10; i++) step(0, i[0], ~i[0], i[1], ~i[1]);
        check("splat_sticky", int'(splat), 1);
        step(1, 0, 0, 1, 0);
        check("splat_reset", int'(walk_left), 1);

        // Dig ignores bumps; falls out when ground disappears.
        step(0, 0, 0, 1, 1);
        check("dig_start", int'(digging), 1);
        step(0, 0, 1, 1, 0);
        step(0, 1, 0, 1, 1);
        check("dig_ignores_bump", int'(digging), 1);
        step(0, 0, 0, 0, 0);
        check("dig_to_fall", int'(aaah), 1);
        step(0, 0, 0, 1, 0);
        check("dig_fall_land", int'(walk_left), 1);

        // Reset mid-fall clears the fall length.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reset_mid_fall", int'(walk_left), 1);
        for (int i = 0; i < FALL_LIMIT; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("fall_cnt_cleared", int'(walk_left), 1);

`ifdef LEMMINGS_BUMP_CNT_EN
        // Five bump turns wrap the 2-bit counter: 1,2,3,0,1.
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, (i % 2) == 0, (i % 2) == 1, 1, 0);
            check("bump_seq", int'(bump_count), (i + 1) % 4);
        end
        step(0, 0, 0, 1, 1);
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        check("bump_no_count", int'(bump_count), 1);
`endif

        // Randomized stimulus with occasional long falls and rare resets.
        run = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, g;
            if (run == 0 && $urandom_range(0, 19) == 0) run = $urandom_range(15, 25);
            if (run > 0) begin
                g = 1'b0; run--;
            end else begin
                g = ($urandom_range(0, 3) != 0);
            end
            r = ($urandom_range(0, 199) == 0);
            step(r, $urandom_range(0, 1), $urandom_range(0, 1), g, ($urandom_range(0, 7) == 0));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/lemmings_splat_fsm.md
Name: lemmings_splat_fsm

Overview:
- Lemming walker FSM, next generation of the walk/fall/dig controller.
- Adds a parametrised fall-height limit: a fall that lasts too long ends in a terminal SPLAT state.
- Adds an explicit splat status output.
- Sits in the same puzzle/FSM block family; one instance per lemming, driven by per-cycle sensor inputs.

Parameters:
- FALL_LIMIT, 20, maximum number of consecutive falling cycles survivable; must be ≥1.
- BUMP_W, 8, width of the optional bump counter.
- Derived, not overridable: FCNT_W = $clog2(FALL_LIMIT+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- bump_left  in  1  obstacle on the left this cycle.
- bump_right  in  1  obstacle on the right this cycle.
- ground  in  1  1 = ground under lemming.
- dig  in  1  dig request.
- walk_left  out  1  state is WL.
- walk_right  out  1  state is WR.
- aaah  out  1  state is FL or FR.
- digging  out  1  state is DL or DR.
- splat  out  1  state is SPLAT.
- bump_count  out  BUMP_W  bump-induced turns; present only with LEMMINGS_BUMP_CNT_EN.

Behaviour:
- Reset is synchronous: reset=1 at a rising edge forces the following, overriding all other inputs:
  - state = WL
  - fall_cnt = 0
  - bump_count = 0
- Reset values of outputs: walk_left=1; walk_right, aaah, digging and splat = 0.
- Reset asserted mid-fall, mid-dig or in SPLAT behaves identically.
- Outputs are Moore, decoded from state only, with no input-to-output combinational path.
- Exactly one output is high in every state.
- States: WL, WR, FL, FR, DL, DR, SPLAT.
- WL/WR, evaluated in priority order:
  1. ground=0 → FL/FR (same direction); fall_cnt := 0.
  2. else dig=1 → DL/DR.
  3. else a bump on the facing side (bump_left in WL, bump_right in WR) → turn to WR/WL.
  4. Bump on the non-facing side → ignored.
  5. Both bumps → turn.
  6. Otherwise hold.
- FL/FR:
  - ground=0 → stay; fall_cnt := min(fall_cnt+1, FALL_LIMIT) (saturating, never wraps).
  - ground=1 and fall_cnt ≥ FALL_LIMIT → SPLAT.
  - ground=1 and fall_cnt < FALL_LIMIT → WL/WR in the pre-fall direction.
  - bump and dig are ignored throughout.
- Equivalent rule: if ground is sampled low on G consecutive edges, aaah is high for exactly G cycles. The lemming splats iff G > FALL_LIMIT.
- DL/DR:
  - ground=1 → stay.
  - ground=0 → FL/FR with fall_cnt := 0.
  - bump and dig are ignored.
- SPLAT: terminal; only reset exits. All inputs are ignored.
- fall_cnt is held at 0 in every non-falling state.

Optional Feature:
- Macro: LEMMINGS_BUMP_CNT_EN.
- Defined:
  - Port bump_count exists.
  - It increments by 1 on each edge where a WL→WR or WR→WL transition is caused by a bump.
  - It wraps modulo 2^BUMP_W.
  - It is cleared only by reset and holds its value in SPLAT.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
1. reset=1 for 2 edges, then ground=1 with no other inputs → walk_left=1 and others 0, stable for 5 cycles. Then bump_left=1 for 1 cycle → walk_right=1 from the next cycle.
2. In WR: ground=0 and dig=1 in the same cycle → aaah=1 (fall beats dig). ground=1 after 3 low cycles → walk_right=1 (direction kept) and digging never asserts.
3. FALL_LIMIT=20:
   - ground low for exactly 20 edges → aaah high 20 cycles, then walk_left=1.
   - Repeat with 21 edges → splat=1 and all others 0.
   - Then toggle all inputs for 10 cycles → splat stays 1.
   - Then reset=1 → walk_left=1 next cycle.
4. WL with dig=1 → digging=1; bump_right/bump_left pulses while digging → no change; ground=0 → aaah=1; ground=1 → walk_left=1.
5. Falling 10 cycles, then reset=1 at the 11th edge with ground still 0 → walk_left=1. Next ground=0 fall of 20 cycles → survives, confirming fall_cnt was cleared.
6. LEMMINGS_BUMP_CNT_EN, BUMP_W=2: 5 bump turns → bump_count sequence 1,2,3,0,1. Bumps while falling or digging do not count.
